// File: rtl/window_sequencer.sv
// Window sequencer: assembles overlapping nucleotide windows, hands each to the
// hasher and commits it as an insert (reference) or query (read) with its id.
module window_sequencer #(
    parameter int WINDOW_SIZE              = 128,
    parameter int KMER_SIZE                = 16,
    parameter int STRIDE                   = WINDOW_SIZE - KMER_SIZE + 1,
    parameter int MAX_WINDOWS_IN_REFERENCE = 1024
) (
    input  logic                            clk,
    input  logic                            reset_window_sequencer_n,
    input  logic                            start,
    input  logic                            is_reference,
    input  logic                            nuc_valid,
    input  logic [1:0]                      nuc_data,
    input  logic                            nuc_last,
    output logic                            nuc_ready,
    output logic [0:WINDOW_SIZE-1][1:0]     window,
    output logic                            reset_window_hasher,
    output logic                            ready_for_hashing,
    input  logic                            hashing_is_done,
    output logic                            is_insert,
    output logic                            is_query,
    output logic [31:0]                     window_id,
    output logic [31:0]                     window_count,
    output logic                            overflow,
    output logic                            stream_done
);

    localparam int FILL_W = $clog2(WINDOW_SIZE + 1);
    localparam logic [FILL_W-1:0] FIRST_TGT = FILL_W'(WINDOW_SIZE);
    localparam logic [FILL_W-1:0] LATER_TGT = FILL_W'(STRIDE);
    localparam logic [31:0]       MAX_ID    = 32'(MAX_WINDOWS_IN_REFERENCE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        HASH_RST  = 3'd2,
        HASH_WAIT = 3'd3,
        COMMIT    = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                      state_r, next_state_s;
    logic                        mode_r;
    logic                        first_r;
    logic                        last_r;
    logic [FILL_W-1:0]           fill_r;
    logic [0:WINDOW_SIZE-1][1:0] window_r;
    logic [31:0]                 window_id_r;
    logic [31:0]                 window_count_r;
    logic                        overflow_r;
    logic                        nuc_ready_r;
    logic                        reset_window_hasher_r;
    logic                        ready_for_hashing_r;
    logic                        is_insert_r;
    logic                        is_query_r;
    logic                        stream_done_r;

    logic                        accept_s;
    logic [FILL_W-1:0]           fill_inc_s;
    logic [FILL_W-1:0]           target_s;
    logic                        complete_s;
    logic                        drop_s;

    assign nuc_ready           = nuc_ready_r;
    assign window              = window_r;
    assign reset_window_hasher = reset_window_hasher_r;
    assign ready_for_hashing   = ready_for_hashing_r;
    assign is_insert           = is_insert_r;
    assign is_query            = is_query_r;
    assign window_id           = window_id_r;
    assign window_count        = window_count_r;
    assign overflow            = overflow_r;
    assign stream_done         = stream_done_r;

    // Acceptance, window-completion and reference-capacity drop decisions
    always_comb begin
        accept_s   = 1'b0;
        fill_inc_s = fill_r + FILL_W'(1);
        target_s   = LATER_TGT;
        complete_s = 1'b0;
        drop_s     = 1'b0;
        if (first_r) begin
            target_s = FIRST_TGT;
        end else begin
            target_s = LATER_TGT;
        end
        if ((state_r == FILL) && nuc_valid && nuc_ready_r) begin
            accept_s   = 1'b1;
            complete_s = (fill_inc_s == target_s);
            drop_s     = complete_s && mode_r && (window_id_r == MAX_ID);
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = FILL;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FILL: begin
                if (accept_s && complete_s && !drop_s) begin
                    next_state_s = HASH_RST;
                end else if (accept_s && nuc_last) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = FILL;
                end
            end
            HASH_RST: next_state_s = HASH_WAIT;
            HASH_WAIT: begin
                if (hashing_is_done) begin
                    next_state_s = COMMIT;
                end else begin
                    next_state_s = HASH_WAIT;
                end
            end
            COMMIT: begin
                if (last_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = FILL;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_window_sequencer_n) begin
        if (!reset_window_sequencer_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Control outputs are registered from the next state so they align with it
    always_ff @(posedge clk or negedge reset_window_sequencer_n) begin
        if (!reset_window_sequencer_n) begin
            nuc_ready_r           <= 1'b0;
            reset_window_hasher_r <= 1'b0;
            ready_for_hashing_r   <= 1'b0;
            is_insert_r           <= 1'b0;
            is_query_r            <= 1'b0;
            stream_done_r         <= 1'b0;
        end else begin
            nuc_ready_r           <= (next_state_s == FILL);
            reset_window_hasher_r <= (next_state_s == HASH_RST);
            ready_for_hashing_r   <= (next_state_s == HASH_WAIT);
            is_insert_r           <= (next_state_s == COMMIT) && mode_r;
            is_query_r            <= (next_state_s == COMMIT) && !mode_r;
            stream_done_r         <= (next_state_s == DONE);
        end
    end

    // Window buffer, fill counter, ids and sticky overflow
    always_ff @(posedge clk or negedge reset_window_sequencer_n) begin
        if (!reset_window_sequencer_n) begin
            mode_r         <= 1'b0;
            first_r        <= 1'b0;
            last_r         <= 1'b0;
            fill_r         <= '0;
            window_r       <= '0;
            window_id_r    <= 32'd0;
            window_count_r <= 32'd0;
            overflow_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mode_r         <= is_reference;
                        first_r        <= 1'b1;
                        last_r         <= 1'b0;
                        fill_r         <= '0;
                        window_id_r    <= 32'd0;
                        window_count_r <= 32'd0;
                        overflow_r     <= 1'b0;
                    end
                end
                FILL: begin
                    if (accept_s) begin
                        window_r <= {window_r[1:WINDOW_SIZE-1], nuc_data};
                        last_r   <= nuc_last;
                        // A dropped window restarts the count here; a hashed one at commit
                        if (drop_s) begin
                            fill_r     <= '0;
                            overflow_r <= 1'b1;
                        end else begin
                            fill_r <= fill_inc_s;
                        end
                        if (complete_s) begin
                            first_r <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    window_id_r    <= window_id_r + 32'd1;
                    window_count_r <= window_count_r + 32'd1;
                    fill_r         <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_sequencer.sv
// Directed bench for window_sequencer with a stream-level reference model and
// a delayed-done hasher model.
module tb_window_sequencer;

    localparam int W    = 8;
    localparam int K    = 4;
    localparam int S    = 5;
    localparam int MAXW = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               is_reference;
    logic               nuc_valid;
    logic [1:0]         nuc_data;
    logic               nuc_last;
    logic               nuc_ready;
    logic [0:W-1][1:0]  window;
    logic               reset_window_hasher;
    logic               ready_for_hashing;
    logic               hashing_is_done;
    logic               is_insert;
    logic               is_query;
    logic [31:0]        window_id;
    logic [31:0]        window_count;
    logic               overflow;
    logic               stream_done;
    logic [2*W-1:0]     win_flat;

    always #5 clk = ~clk;
    assign win_flat = window;

    window_sequencer #(
        .WINDOW_SIZE(W), .KMER_SIZE(K), .STRIDE(S), .MAX_WINDOWS_IN_REFERENCE(MAXW)
    ) dut (
        .clk(clk), .reset_window_sequencer_n(rst_n), .start(start),
        .is_reference(is_reference), .nuc_valid(nuc_valid), .nuc_data(nuc_data),
        .nuc_last(nuc_last), .nuc_ready(nuc_ready), .window(window),
        .reset_window_hasher(reset_window_hasher), .ready_for_hashing(ready_for_hashing),
        .hashing_is_done(hashing_is_done), .is_insert(is_insert), .is_query(is_query),
        .window_id(window_id), .window_count(window_count), .overflow(overflow),
        .stream_done(stream_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream-level model: windows end at nucleotide counts W, W+S, W+2S, ...
    typedef struct {
        logic [31:0]    id;
        logic [2*W-1:0] win;
        logic           is_ref;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] m_nucs[$];
    int         m_id;
    logic       m_mode;
    logic       m_ovf;

    function automatic logic [2*W-1:0] last_window();
        logic [2*W-1:0] w;
        int n;
        n = m_nucs.size();
        w = '0;
        for (int j = 0; j < W; j++) begin
            w[(W-1-j)*2 +: 2] = m_nucs[n-W+j];
        end
        return w;
    endfunction

    task automatic model_start(input logic m);
        m_nucs.delete();
        m_id   = 0;
        m_mode = m;
        m_ovf  = 1'b0;
    endtask

    task automatic model_accept(input logic [1:0] d);
        exp_t e;
        int n;
        m_nucs.push_back(d);
        n = m_nucs.size();
        if (n >= W && ((n - W) % S) == 0) begin
            if (m_mode && m_id >= MAXW) begin
                m_ovf = 1'b1;
            end else begin
                e.id     = 32'(m_id);
                e.win    = last_window();
                e.is_ref = m_mode;
                exp_q.push_back(e);
                m_id++;
            end
        end
    endtask

    // Hasher model: done one cycle, three cycles after ready_for_hashing rises
    logic stall;
    int   hcnt;
    initial begin
        hashing_is_done = 1'b0;
        hcnt = 0;
        forever begin
            @(negedge clk);
            if (ready_for_hashing && !stall) begin
                hcnt++;
                hashing_is_done = (hcnt >= 3);
                if (hcnt >= 3) hcnt = 0;
            end else begin
                hcnt = 0;
                hashing_is_done = 1'b0;
            end
        end
    end

    int             insert_cnt = 0;
    int             query_cnt  = 0;
    int             done_cnt   = 0;
    logic [31:0]    last_commit_id;
    logic [2*W-1:0] last_commit_win;

    // Per-cycle compare against the model queue
    always @(negedge clk) begin
        if (rst_n) begin
            chk("commit_excl", 64'(is_insert & is_query), 64'd0);
            chk("ready_excl", 64'(nuc_ready & (reset_window_hasher | ready_for_hashing | is_insert | is_query)), 64'd0);
            if (reset_window_hasher || ready_for_hashing) begin
                if (exp_q.size() == 0) begin
                    chk("hash_pending", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("hash_window", 64'(win_flat), 64'(exp_q[0].win));
                    chk("hash_id", 64'(window_id), 64'(exp_q[0].id));
                end
            end
            if (is_insert || is_query) begin
                if (exp_q.size() == 0) begin
                    chk("commit_pending", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("commit_id", 64'(window_id), 64'(exp_q[0].id));
                    chk("commit_type", 64'(is_insert), 64'(exp_q[0].is_ref));
                    chk("commit_window", 64'(win_flat), 64'(exp_q[0].win));
                    void'(exp_q.pop_front());
                end
                last_commit_id  = window_id;
                last_commit_win = win_flat;
                if (is_insert) insert_cnt++;
                if (is_query)  query_cnt++;
            end
            if (stream_done) done_cnt++;
        end
    end

    task automatic send(input logic [1:0] d, input logic last);
        int   guard;
        logic sent;
        guard = 0;
        sent  = 1'b0;
        while (!sent) begin
            @(negedge clk);
            nuc_valid = 1'b1;
            nuc_data  = d;
            nuc_last  = last;
            if (nuc_ready) begin
                model_accept(d);
                sent = 1'b1;
            end else begin
                guard++;
                if (guard > 500) begin
                    chk("send_timeout", 64'(nuc_ready), 64'd1);
                    sent = 1'b1;
                end
            end
        end
    endtask

    task automatic send_stream(input int first, input int n, input logic last, input logic clear);
        for (int i = 0; i < n; i++) begin
            send(2'((first + i) % 4), last && (i == n - 1));
        end
        if (clear) begin
            @(negedge clk);
            nuc_valid = 1'b0;
            nuc_last  = 1'b0;
        end
    endtask

    task automatic do_start(input logic m);
        @(negedge clk);
        start        = 1'b1;
        is_reference = m;
        model_start(m);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int g;
        g = 0;
        while (done_cnt == prev && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", 64'(done_cnt != prev), 64'd1);
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!ready_for_hashing && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("ready_seen", 64'(ready_for_hashing), 64'd1);
    endtask

    int             prev_done;
    int             i0;
    int             q0;
    logic [2*W-1:0] held_win;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        is_reference = 1'b0;
        nuc_valid    = 1'b0;
        nuc_data     = 2'd0;
        nuc_last     = 1'b0;
        stall        = 1'b0;
        model_start(1'b0);

        #23;
        chk("rst_ready", 64'(nuc_ready), 64'd0);
        chk("rst_window", 64'(win_flat), 64'd0);
        chk("rst_id", 64'(window_id), 64'd0);
        chk("rst_outs", 64'({reset_window_hasher, ready_for_hashing, is_insert, is_query, overflow, stream_done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference stream of 18: windows at offsets 0, 5, 10
        prev_done = done_cnt; i0 = insert_cnt; q0 = query_cnt;
        do_start(1'b1);
        send_stream(0, 18, 1'b1, 1'b1);
        wait_done(prev_done);
        chk("ref18_inserts", 64'(insert_cnt - i0), 64'd3);
        chk("ref18_queries", 64'(query_cnt - q0), 64'd0);
        chk("ref18_count", 64'(window_count), 64'd3);
        chk("ref18_last_id", 64'(last_commit_id), 64'd2);
        chk("ref18_last_win", 64'(last_commit_win), 64'hB1B1);
        chk("ref18_model_count", 64'(window_count), 64'(m_id));
        chk("ref18_ovf", 64'(overflow), 64'd0);

        // Read stream of 16: tail of three discarded
        prev_done = done_cnt; i0 = insert_cnt; q0 = query_cnt;
        do_start(1'b0);
        send_stream(0, 16, 1'b1, 1'b1);
        chk("rd16_done_timing", 64'(stream_done), 64'd1);
        wait_done(prev_done);
        chk("rd16_queries", 64'(query_cnt - q0), 64'd2);
        chk("rd16_inserts", 64'(insert_cnt - i0), 64'd0);
        chk("rd16_count", 64'(window_count), 64'd2);
        chk("rd16_last_id", 64'(last_commit_id), 64'd1);
        chk("rd16_last_win", 64'(last_commit_win), 64'h6C6C);
        chk("rd16_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reference stream of 33: capacity 4, two windows dropped
        prev_done = done_cnt; i0 = insert_cnt;
        do_start(1'b1);
        send_stream(0, 33, 1'b1, 1'b1);
        wait_done(prev_done);
        chk("ref33_inserts", 64'(insert_cnt - i0), 64'd4);
        chk("ref33_ovf", 64'(overflow), 64'd1);
        chk("ref33_model_ovf", 64'(overflow), 64'(m_ovf));
        chk("ref33_count", 64'(window_count), 64'd4);
        chk("ref33_last_id", 64'(last_commit_id), 64'd3);

        // New start clears overflow; then hold the hasher off for 50 cycles
        prev_done = done_cnt; i0 = insert_cnt;
        do_start(1'b1);
        chk("start_clears_ovf", 64'(overflow), 64'd0);
        stall = 1'b1;
        send_stream(0, 8, 1'b0, 1'b0);
        wait_ready();
        held_win = win_flat;
        nuc_data = 2'd3;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("stall_ready", 64'(ready_for_hashing), 64'd1);
            chk("stall_nuc_ready", 64'(nuc_ready), 64'd0);
            chk("stall_window", 64'(win_flat), 64'(held_win));
            chk("stall_no_commit", 64'(insert_cnt - i0), 64'd0);
        end
        stall = 1'b0;
        send_stream(0, 2, 1'b1, 1'b1);
        wait_done(prev_done);
        chk("stall_inserts", 64'(insert_cnt - i0), 64'd1);
        chk("stall_win", 64'(last_commit_win), 64'h1B1B);

        // Reset asserted in HASH_WAIT aborts without commit
        i0 = insert_cnt;
        do_start(1'b1);
        stall = 1'b1;
        send_stream(0, 8, 1'b0, 1'b1);
        wait_ready();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(ready_for_hashing), 64'd0);
        chk("arst_window", 64'(win_flat), 64'd0);
        chk("arst_outs", 64'({nuc_ready, reset_window_hasher, is_insert, is_query, overflow, stream_done}), 64'd0);
        chk("arst_ids", 64'({window_id, window_count}), 64'd0);
        exp_q.delete();
        stall = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_no_insert", 64'(insert_cnt - i0), 64'd0);
        rst_n = 1'b1;
        prev_done = done_cnt;
        do_start(1'b1);
        send_stream(0, 8, 1'b1, 1'b1);
        wait_done(prev_done);
        chk("arst_fresh_inserts", 64'(insert_cnt - i0), 64'd1);
        chk("arst_fresh_id", 64'(last_commit_id), 64'd0);

        // Start during FILL with the mode flipped is ignored
        prev_done = done_cnt; i0 = insert_cnt; q0 = query_cnt;
        do_start(1'b0);
        send_stream(0, 3, 1'b0, 1'b0);
        @(negedge clk);
        nuc_valid    = 1'b0;
        start        = 1'b1;
        is_reference = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_stream(3, 5, 1'b1, 1'b1);
        wait_done(prev_done);
        chk("restart_queries", 64'(query_cnt - q0), 64'd1);
        chk("restart_inserts", 64'(insert_cnt - i0), 64'd0);
        chk("restart_count", 64'(window_count), 64'd1);
        chk("restart_win", 64'(last_commit_win), 64'h1B1B);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
